// File: rtl/mult_stream_ctrl.sv
// mult_stream_ctrl: operand-load / result-readout controller for an 8x8 multiplier core.
// Accepts operand pairs over valid/ready, drives them onto the core, waits the core
// latency, captures the 16-bit product and streams it out low byte first.
module mult_stream_ctrl #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  mult_count
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StSendLo,
    StSendHi
  } state_e;

  // Core latency is held in a 3-bit down-counter, so only 0..7 is representable.
  localparam logic [2:0] LatInit = 3'(MUL_LAT);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] prod_q;
  logic [7:0]  mul_a_q;
  logic [7:0]  mul_b_q;
  logic [7:0]  count_q;

  // Control FSM and datapath registers; ena=0 freezes every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      prod_q  <= 16'd0;
      mul_a_q <= 8'd0;
      mul_b_q <= 8'd0;
      count_q <= 8'd0;
    end else if (ena) begin
      unique case (state_q)
        StIdle: begin
          // in_ready is high whenever we are here with ena=1
          if (in_valid) begin
            mul_a_q <= in_a;
            mul_b_q <= in_b;
            cnt_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 3'd0) begin
            prod_q  <= mul_p;
            state_q <= StSendLo;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StSendLo: begin
          if (out_ready) begin
            state_q <= StSendHi;
          end
        end
        StSendHi: begin
          if (out_ready) begin
            count_q <= count_q + 8'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake strobes are gated by ena so a frozen controller never offers or takes data.
  always_comb begin
    in_ready  = (state_q == StIdle) & ena;
    out_valid = ((state_q == StSendLo) | (state_q == StSendHi)) & ena;
    busy      = (state_q != StIdle);
  end

  // Result byte select; zero outside the send states so idle/reset outputs read 0.
  always_comb begin
    out_byte = 8'd0;
    out_last = 1'b0;
    unique case (state_q)
      StSendLo: out_byte = prod_q[7:0];
      StSendHi: begin
        out_byte = prod_q[15:8];
        out_last = 1'b1;
      end
      default: begin
        out_byte = 8'd0;
        out_last = 1'b0;
      end
    endcase
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mult_count = count_q;

endmodule

// File: doc/mult_stream_ctrl.md
# mult_stream_ctrl

Operand-load and result-readout controller that sits directly upstream and downstream of the 8x8 array multiplier core in `tt_um_b_8_array_multiplier`. It accepts operand pairs over a valid/ready handshake and registers them onto the multiplier inputs. It waits the core's latency, captures the 16-bit product, and streams it out as two bytes over a second valid/ready handshake. It also keeps a wrapping count of completed multiplications for bring-up visibility on the spare IOs.

## Interface
Parameters:
- `MUL_LAT`, default 0: clock cycles the core needs from stable `mul_a`/`mul_b` to valid `mul_p`. Legal range 0..7.

Ports:
- `clk`  in  1  system clock, all state on the rising edge.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `ena`  in  1  design enable; 0 freezes all state and blocks both handshakes.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  controller can accept operands.
- `in_a`  in  8  operand A, unsigned.
- `in_b`  in  8  operand B, unsigned.
- `mul_a`  out  8  registered operand A to the core.
- `mul_b`  out  8  registered operand B to the core.
- `mul_p`  in  16  product from the core.
- `out_valid`  out  1  result byte present.
- `out_ready`  in  1  consumer takes the byte.
- `out_byte`  out  8  result byte: low byte first, then high byte.
- `out_last`  out  1  high on the high (second) byte.
- `busy`  out  1  high in any state other than IDLE.
- `mult_count`  out  8  completed multiplications, wraps modulo 256.

## Operation
States and register updates (all happen only on edges where `ena`=1):
- IDLE: `in_ready`=1.
  - On `in_valid` & `in_ready`: `mul_a`<=`in_a`, `mul_b`<=`in_b`, `cnt`<=`MUL_LAT`; go to WAIT.
- WAIT: if `cnt`==0, `prod`<=`mul_p` and go to SEND_LO; otherwise `cnt`<=`cnt`-1.
- SEND_LO: `out_valid`=1, `out_byte`=`prod[7:0]`, `out_last`=0. On `out_ready`, go to SEND_HI.
- SEND_HI: `out_valid`=1, `out_byte`=`prod[15:8]`, `out_last`=1. On `out_ready`, `mult_count`<=`mult_count`+1 (255 wraps to 0) and go to IDLE.

Rules:
- `in_ready` = (state==IDLE) & `ena`.
- `out_valid` = (state in SEND_LO/SEND_HI) & `ena`.
- No other combinational path exists from inputs to outputs.
- `in_ready` is 0 while busy; at most one operation is in flight.
- `mul_a`/`mul_b` hold their value until the next accept, so the core output stays stable.
- `ena`=0: no register changes, handshakes are not taken, and `in_ready`/`out_valid` read 0. Operation resumes exactly where it stopped.
- `out_byte`/`out_last` hold while `out_valid`=1 and `out_ready`=0.
- Reset is asynchronous and immediate:
  - state IDLE, `mul_a`=`mul_b`=0, `prod`=0, `cnt`=0, `mult_count`=0.
  - Output values during reset: `busy`=0, `out_valid`=0, `out_byte`=0, `out_last`=0, and `in_ready` equals `ena`.
  - Reset mid-operation discards the operands and product; `mult_count` returns to 0.

## Timing
- Accept at edge N → `mul_a`/`mul_b` valid after edge N.
- Product captured at edge N+1+`MUL_LAT`; `out_valid` high after that edge (with `ena` held at 1).
- With `out_ready` tied high:
  - low byte transfers at edge N+2+`MUL_LAT`, high byte at N+3+`MUL_LAT`;
  - `in_ready` high after N+3+`MUL_LAT`.
- Peak throughput: one operation per `MUL_LAT`+4 cycles.
- `mult_count` increments on the same edge that transfers the high byte.
- Each cycle with `ena`=0 adds exactly one cycle to every subsequent event.

## Test plan
The bench models the core as `mul_a`*`mul_b` delayed by `MUL_LAT` registers.
- `MUL_LAT`=0, A=13, B=11, `out_ready`=1:
  - low byte 0x8F at edge N+2, then 0x00 with `out_last`=1 at N+3;
  - `mult_count`=1; `in_ready` back high after N+3.
- A=255, B=255:
  - bytes 0x01 then 0xFE;
  - A=0, B=200 next gives 0x00, 0x00.
- Backpressure: hold `out_ready`=0 for 3 cycles in SEND_LO, and `in_valid`=1 with new operands throughout:
  - `out_byte` stays 0x8F, `in_ready` stays 0, no second operation accepted;
  - after release, both bytes arrive in order.
- `MUL_LAT`=3, A=200, B=3:
  - capture at edge N+4, bytes 0x58 then 0x02;
  - dropping `ena` for 2 cycles inside WAIT delays capture to N+6.
- Assert `rst_n`=0 while in SEND_HI:
  - `out_valid`=0, `busy`=0, `mult_count`=0 immediately, without waiting for a clock edge;
  - after release, a new 2x3 operation streams 0x06, 0x00.
- Run 257 back-to-back operations: `mult_count` reads 255 after the 255th and 1 after the 257th.
